// File: rtl/astar_pkg.sv
// Shared A* definitions: open-list geometry, command/status encodings and coordinate types.
// Used by the open-list writer, the linear searcher and the best-node selector.
package astar_pkg;

  localparam int DEPTH   = 400;
  localparam int COORD_W = 8;
  localparam int IDX_W   = 9;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [IDX_W-1:0]   idx_t;

  localparam idx_t DEPTH_IDX = idx_t'(DEPTH);

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_INSERT = 2'b01,
    OP_REMOVE = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    STAT_OK        = 2'b00,
    STAT_FULL      = 2'b01,
    STAT_BAD_INDEX = 2'b10,
    STAT_DUP       = 2'b11
  } status_e;

endpackage

// File: rtl/open_list_writer.sv
// A* open-list write manager: owns the x/y arrays and live count, runs INSERT/REMOVE/CLEAR.
// Define OPEN_LIST_DUP_CHECK_EN to make INSERT scan the live entries and reject duplicates.
module open_list_writer
  import astar_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x,
  input  logic [COORD_W-1:0] cmd_y,
  input  logic [IDX_W-1:0]   cmd_index,
  output logic               done,
  output logic [1:0]         status,
  output logic [IDX_W-1:0]   count,
  output logic               full,
  output logic               empty,
  input  logic [IDX_W-1:0]   rd_index,
  output logic [COORD_W-1:0] rd_x,
  output logic [COORD_W-1:0] rd_y
);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_INSERT_WRITE = 3'd1,
    S_REMOVE_MOVE  = 3'd2,
    S_CLEAR_RUN    = 3'd3,
    S_DUP_SCAN     = 3'd4
  } state_e;

  state_e  state_q,     state_d;
  logic    cmd_ready_q, cmd_ready_d;
  logic    done_q,      done_d;
  status_e status_q,    status_d;
  idx_t    count_q,     count_d;
  op_e     op_q,        op_d;
  coord_t  x_q,         x_d;
  coord_t  y_q,         y_d;
  idx_t    idx_q,       idx_d;
  coord_t  rd_x_q,      rd_x_d;
  coord_t  rd_y_q,      rd_y_d;
`ifdef OPEN_LIST_DUP_CHECK_EN
  idx_t    scan_q,      scan_d;
`endif

  coord_t openx [DEPTH];
  coord_t openy [DEPTH];

  logic   wr_en;
  idx_t   wr_addr;
  coord_t wr_x;
  coord_t wr_y;
  idx_t   last_idx;

  // Guarded so the internal second read never addresses past the array when the list is empty.
  assign last_idx = (count_q == '0) ? '0 : count_q - idx_t'(1);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    done_d      = 1'b0;
    status_d    = status_q;
    count_d     = count_q;
    op_d        = op_q;
    x_d         = x_q;
    y_d         = y_q;
    idx_d       = idx_q;
`ifdef OPEN_LIST_DUP_CHECK_EN
    scan_d      = scan_q;
`endif
    wr_en       = 1'b0;
    wr_addr     = count_q;
    wr_x        = x_q;
    wr_y        = y_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d        = op_e'(cmd_op);
          x_d         = cmd_x;
          y_d         = cmd_y;
          idx_d       = cmd_index;
          cmd_ready_d = 1'b0;
          case (op_e'(cmd_op))
            OP_INSERT: begin
              state_d = S_INSERT_WRITE;
`ifdef OPEN_LIST_DUP_CHECK_EN
              // Full and empty lists need no scan: the write stage rejects or writes directly.
              if (count_q != '0 && count_q != DEPTH_IDX) begin
                state_d = S_DUP_SCAN;
                scan_d  = '0;
              end
`endif
            end
            OP_REMOVE: state_d = S_REMOVE_MOVE;
            default:   state_d = S_CLEAR_RUN;
          endcase
        end
      end

      S_INSERT_WRITE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        done_d      = 1'b1;
        if (count_q == DEPTH_IDX) begin
          status_d = STAT_FULL;
        end else begin
          wr_en    = 1'b1;
          wr_addr  = count_q;
          count_d  = count_q + idx_t'(1);
          status_d = STAT_OK;
        end
      end

      S_REMOVE_MOVE: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        done_d      = 1'b1;
        if (idx_q >= count_q) begin
          status_d = STAT_BAD_INDEX;
        end else begin
          // Fill the hole with the last live entry; removing the last entry only shrinks the count.
          wr_en    = (idx_q != last_idx);
          wr_addr  = idx_q;
          wr_x     = openx[last_idx];
          wr_y     = openy[last_idx];
          count_d  = last_idx;
          status_d = STAT_OK;
        end
      end

      // Shared completion state for CLEAR and NOP so both keep the two-cycle transaction timing.
      S_CLEAR_RUN: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        done_d      = 1'b1;
        status_d    = STAT_OK;
        if (op_q == OP_CLEAR) count_d = '0;
      end

`ifdef OPEN_LIST_DUP_CHECK_EN
      S_DUP_SCAN: begin
        if (openx[scan_q] == x_q && openy[scan_q] == y_q) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          done_d      = 1'b1;
          status_d    = STAT_DUP;
        end else if (scan_q == last_idx) begin
          state_d = S_INSERT_WRITE;
        end else begin
          scan_d = scan_q + idx_t'(1);
        end
      end
`endif

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
      end
    endcase
  end

  always_comb begin
    rd_x_d = '0;
    rd_y_d = '0;
    if (rd_index < DEPTH_IDX) begin
      rd_x_d = openx[rd_index];
      rd_y_d = openy[rd_index];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      done_q      <= 1'b0;
      status_q    <= STAT_OK;
      count_q     <= '0;
      op_q        <= OP_NOP;
      x_q         <= '0;
      y_q         <= '0;
      idx_q       <= '0;
      rd_x_q      <= '0;
      rd_y_q      <= '0;
`ifdef OPEN_LIST_DUP_CHECK_EN
      scan_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      status_q    <= status_d;
      count_q     <= count_d;
      op_q        <= op_d;
      x_q         <= x_d;
      y_q         <= y_d;
      idx_q       <= idx_d;
      rd_x_q      <= rd_x_d;
      rd_y_q      <= rd_y_d;
`ifdef OPEN_LIST_DUP_CHECK_EN
      scan_q      <= scan_d;
`endif
    end
  end

  // NOTE: the arrays have no reset so they map onto RAM; stale contents are dead once count is 0.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      openx[wr_addr] <= wr_x;
      openy[wr_addr] <= wr_y;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign done      = done_q;
  assign status    = status_q;
  assign count     = count_q;
  assign full      = (count_q == DEPTH_IDX);
  assign empty     = (count_q == '0);
  assign rd_x      = rd_x_q;
  assign rd_y      = rd_y_q;

endmodule

// File: tb/tb_open_list_writer.sv
// Directed self-checking bench for open_list_writer; expected values are hand-computed.
// Define OPEN_LIST_DUP_CHECK_EN for both bench and RTL to exercise the duplicate scan.
module tb_open_list_writer;
  import astar_pkg::*;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [COORD_W-1:0] cmd_x;
  logic [COORD_W-1:0] cmd_y;
  logic [IDX_W-1:0]   cmd_index;
  logic               done;
  logic [1:0]         status;
  logic [IDX_W-1:0]   count;
  logic               full;
  logic               empty;
  logic [IDX_W-1:0]   rd_index;
  logic [COORD_W-1:0] rd_x;
  logic [COORD_W-1:0] rd_y;

  int n_checks = 0;
  int n_errors = 0;

  open_list_writer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_index (cmd_index),
    .done      (done),
    .status    (status),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .rd_index  (rd_index),
    .rd_x      (rd_x),
    .rd_y      (rd_y)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Issues one command from posedge+1 alignment; returns status and edges from accept to done.
  task automatic do_cmd(input logic [1:0] op, input int x, input int y, input int idx,
                        output int st, output int lat);
    int w;
    st  = -1;
    lat = -1;
    cmd_op    = op;
    cmd_x     = COORD_W'(x);
    cmd_y     = COORD_W'(y);
    cmd_index = IDX_W'(idx);
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(posedge Clk); #1;
      w++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge Clk); #1;
    // Scramble the inputs after acceptance: the block must use its captured copy.
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_x     = 8'hAA;
    cmd_y     = 8'h55;
    cmd_index = '1;
    for (int k = 1; k <= 1000; k++) begin
      @(posedge Clk); #1;
      if (done) begin
        st  = int'(status);
        lat = k;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 0, 1);
  endtask

  task automatic cmd_chk(input string tag, input logic [1:0] op, input int x, input int y,
                         input int idx, input int exp_st, input int exp_lat, input int exp_cnt);
    int st, lat;
    do_cmd(op, x, y, idx, st, lat);
    check({tag, "_status"}, st, exp_st);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_count"}, count, exp_cnt);
  endtask

  task automatic read_chk(input string tag, input int idx, input int ex, input int ey);
    rd_index = IDX_W'(idx);
    @(posedge Clk); #1;
    check({tag, "_x"}, rd_x, ex);
    check({tag, "_y"}, rd_y, ey);
  endtask

  initial begin
    int st, lat, dones, saw;
    Reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_index = '0;
    rd_index  = '0;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_rd_x", rd_x, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;

    // Single insert, readback, done is a one-cycle pulse.
    cmd_chk("ins35", 2'b01, 3, 5, 0, 0, 1, 1);
    @(posedge Clk); #1;
    check("done_pulse_width", done, 0);
    check("ins35_status_held", status, 0);
    read_chk("rd0", 0, 3, 5);

    // Remove with swap-from-last, bad index, remove-last, NOP.
    cmd_chk("clr1", 2'b11, 0, 0, 0, 0, 1, 0);
    check("clr1_empty", empty, 1);
    cmd_chk("ins11", 2'b01, 1, 1, 0, 0, 1, 1);
    cmd_chk("ins22", 2'b01, 2, 2, 0, 0, 1, 2);
    cmd_chk("ins33", 2'b01, 3, 3, 0, 0, 1, 3);
    cmd_chk("rm0", 2'b10, 0, 0, 0, 0, 1, 2);
    read_chk("rm0_e0", 0, 3, 3);
    read_chk("rm0_e1", 1, 2, 2);
    cmd_chk("rm2_bad", 2'b10, 0, 0, 2, 2, 1, 2);
    cmd_chk("rm1_last", 2'b10, 0, 0, 1, 0, 1, 1);
    read_chk("rm1_e0", 0, 3, 3);
    cmd_chk("nop", 2'b00, 9, 9, 0, 0, 1, 1);
    read_chk("nop_e0", 0, 3, 3);

    // Fill to capacity, overflow, out-of-range read, clear.
    cmd_chk("clr2", 2'b11, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < DEPTH; i++) do_cmd(2'b01, i % 256, i / 256, 0, st, lat);
    check("fill_count", count, 400);
    check("fill_full", full, 1);
    check("fill_empty", empty, 0);
    read_chk("rd399", 399, 143, 1);
    read_chk("rd256", 256, 0, 1);
    read_chk("rd400_oor", 400, 0, 0);
    cmd_chk("ins401", 2'b01, 7, 7, 0, 1, 1, 400);
    read_chk("rd399_after_full", 399, 143, 1);
    cmd_chk("clr3", 2'b11, 0, 0, 0, 0, 1, 0);
    check("clr3_empty", empty, 1);
    check("clr3_full", full, 0);

    // Back-to-back inserts with cmd_valid held high: one every two cycles.
    cmd_op    = 2'b01;
    cmd_x     = '0;
    cmd_y     = 8'd50;
    cmd_valid = 1'b1;
    dones     = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge Clk); #1;
      if (done) begin
        dones++;
        cmd_x = COORD_W'(dones);
      end
    end
    cmd_valid = 1'b0;
    check("b2b_dones", dones, 10);
    check("b2b_count", count, 10);
    read_chk("b2b_e0", 0, 0, 50);
    read_chk("b2b_e9", 9, 9, 50);

    // Reset during INSERT_WRITE abandons the command.
    cmd_op    = 2'b01;
    cmd_x     = 8'd1;
    cmd_y     = 8'd2;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    check("rstw_busy_ready", cmd_ready, 0);
    Reset = 1'b1;
    #1;
    check("rstw_async_count", count, 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    saw = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge Clk); #1;
      if (done) saw = 1;
    end
    check("rstw_no_done", saw, 0);
    check("rstw_count", count, 0);
    check("rstw_ready", cmd_ready, 1);
    check("rstw_empty", empty, 1);

`ifdef OPEN_LIST_DUP_CHECK_EN
    // Duplicate scan: one entry per edge, stop on first match.
    cmd_chk("d_ins44", 2'b01, 4, 4, 0, 0, 1, 1);
    cmd_chk("d_ins79", 2'b01, 7, 9, 0, 0, 2, 2);
    cmd_chk("d_dup79", 2'b01, 7, 9, 0, 3, 2, 2);
    cmd_chk("d_dup44", 2'b01, 4, 4, 0, 3, 1, 2);
    cmd_chk("d_ins88", 2'b01, 8, 8, 0, 0, 3, 3);
    read_chk("d_e2", 2, 8, 8);

    // Reset during DUP_SCAN.
    cmd_op    = 2'b01;
    cmd_x     = 8'd0;
    cmd_y     = 8'd0;
    cmd_valid = 1'b1;
    @(posedge Clk); #1;
    cmd_valid = 1'b0;
    @(posedge Clk); #1;
    check("rsts_busy_ready", cmd_ready, 0);
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    saw = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      if (done) saw = 1;
    end
    check("rsts_no_done", saw, 0);
    check("rsts_count", count, 0);
    check("rsts_ready", cmd_ready, 1);
`else
    // Without the scan a duplicate is written blindly.
    cmd_chk("n_ins79", 2'b01, 7, 9, 0, 0, 1, 1);
    cmd_chk("n_dup79", 2'b01, 7, 9, 0, 0, 1, 2);
    read_chk("n_e1", 1, 7, 9);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
